// File: rtl/fp_exec_arith.sv
// Execute-stage float unit: pipelined IEEE-754 single add/sub (7 stages), divide and
// float-to-int (6 stages each), all fed from one shared operand register every cycle.
module fp_exec_arith (
   input  logic        clock,
   input  logic        rst,
   input  logic        add_sub,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] addsub_result,
   output logic [31:0] div_result,
   output logic        division_by_zero,
   output logic [31:0] ftoi_result
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef struct packed {
      logic              sign;
      logic signed [9:0] ex;
      logic [23:0]       mb;
      logic [24:0]       rem;
      logic [27:0]       quo;
      logic              spec;
      logic [31:0]       spec_val;
      logic              dbz;
   } div_st_t;

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic sa, sb, sr, rnd;
      logic [7:0] ea, eb, ebig, d;
      logic [23:0] mbig, msml;
      logic [4:0] sh, lz;
      logic [58:0] tmp;
      logic [26:0] al, norm;
      logic [27:0] sum;
      logic signed [9:0] ex;
      logic [24:0] m25;
      sa = a[31]; sb = b[31]; ea = a[30:23]; eb = b[30:23];
      if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) return QNAN;
      if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? a : QNAN;
      if (ea == 8'hFF) return a;
      if (eb == 8'hFF) return b;
      if (ea == 8'd0 && eb == 8'd0) return {sa & sb, 31'd0};
      if (ea == 8'd0) return b;
      if (eb == 8'd0) return a;
      if (a[30:0] >= b[30:0]) begin
         sr = sa; ebig = ea; d = ea - eb; mbig = {1'b1, a[22:0]}; msml = {1'b1, b[22:0]};
      end else begin
         sr = sb; ebig = eb; d = eb - ea; mbig = {1'b1, b[22:0]}; msml = {1'b1, a[22:0]};
      end
      // Align the smaller operand; everything shifted past the round bit folds into sticky.
      sh = (d > 8'd31) ? 5'd31 : d[4:0];
      tmp = {msml, 3'b000, 32'd0} >> sh;
      al = tmp[58:32];
      al[0] = al[0] | (|tmp[31:0]);
      if (sa == sb) sum = {1'b0, mbig, 3'b000} + {1'b0, al};
      else          sum = {1'b0, mbig, 3'b000} - {1'b0, al};
      if (sum == 28'd0) return 32'd0;
      ex = 10'(ebig);
      lz = 5'd0;
      if (sum[27]) begin
         norm = sum[27:1];
         norm[0] = norm[0] | sum[0];
         ex = ex + 10'sd1;
      end else begin
         for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
         norm = sum[26:0] << lz;
         ex = ex - 10'(lz);
      end
      if (ex <= 10'sd0) return {sr, 31'd0};
      rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
      m25 = {1'b0, norm[26:3]} + {24'd0, rnd};
      if (m25[24]) ex = ex + 10'sd1;
      if (ex >= 10'sd255) return {sr, 8'hFF, 23'd0};
      return {sr, ex[7:0], m25[22:0]};
   endfunction

   function automatic logic [31:0] fp_ftoi(input logic [31:0] a);
      logic [7:0] e;
      logic [23:0] m;
      logic [49:0] ext;
      logic [31:0] mag;
      logic rnd;
      e = a[30:23];
      m = {1'b1, a[22:0]};
      if (e == 8'hFF && a[22:0] != 23'd0) return 32'h7FFFFFFF;
      if (e >= 8'd158) return a[31] ? 32'h80000000 : 32'h7FFFFFFF;
      if (e <= 8'd100) return 32'd0;
      if (e >= 8'd150) begin
         mag = {8'd0, m} << (e - 8'd150);
      end else begin
         ext = {m, 26'd0} >> (8'd150 - e);
         rnd = ext[25] & ((|ext[24:0]) | ext[26]);
         mag = {8'd0, ext[49:26]} + {31'd0, rnd};
      end
      return a[31] ? -mag : mag;
   endfunction

   // Seven quotient bits of restoring division per pipeline stage.
   function automatic div_st_t div_step(input div_st_t s);
      div_st_t r;
      r = s;
      for (int i = 0; i < 7; i++) begin
         if (r.rem >= {1'b0, r.mb}) begin
            r.rem = r.rem - {1'b0, r.mb};
            r.quo = {r.quo[26:0], 1'b1};
         end else begin
            r.quo = {r.quo[26:0], 1'b0};
         end
         r.rem = {r.rem[23:0], 1'b0};
      end
      return r;
   endfunction

   logic [31:0] a_q, a_d, b_q, b_d;
   logic        add_sub_q, add_sub_d;
   logic [31:0] add_pipe_q [6];
   logic [31:0] add_pipe_d [6];
   logic [31:0] ftoi_pipe_q [5];
   logic [31:0] ftoi_pipe_d [5];
   logic [31:0] div_res_q, div_res_d;
   logic        dbz_q, dbz_d;
   div_st_t     div_init;
   div_st_t     div_q [4];

   always_comb begin
      a_d = dataa;
      b_d = datab;
      add_sub_d = add_sub;
      add_pipe_d[0] = fp_add(a_q, {b_q[31] ^ ~add_sub_q, b_q[30:0]});
      for (int i = 1; i < 6; i++) add_pipe_d[i] = add_pipe_q[i-1];
      ftoi_pipe_d[0] = fp_ftoi(a_q);
      for (int i = 1; i < 5; i++) ftoi_pipe_d[i] = ftoi_pipe_q[i-1];
   end

   always_comb begin
      div_init = '0;
      div_init.sign = a_q[31] ^ b_q[31];
      div_init.ex = 10'(a_q[30:23]) - 10'(b_q[30:23]) + 10'd127;
      div_init.mb = {1'b1, b_q[22:0]};
      div_init.rem = {2'b01, a_q[22:0]};
      if ((a_q[30:23] == 8'hFF && a_q[22:0] != 23'd0) || (b_q[30:23] == 8'hFF && b_q[22:0] != 23'd0)
          || (a_q[30:23] == 8'd0 && b_q[30:23] == 8'd0) || (a_q[30:23] == 8'hFF && b_q[30:23] == 8'hFF)) begin
         div_init.spec = 1'b1;
         div_init.spec_val = QNAN;
      end else if (a_q[30:23] == 8'hFF || b_q[30:23] == 8'd0) begin
         div_init.spec = 1'b1;
         div_init.spec_val = {div_init.sign, 8'hFF, 23'd0};
         div_init.dbz = (b_q[30:23] == 8'd0) && (a_q[30:23] != 8'hFF);
      end else if (b_q[30:23] == 8'hFF || a_q[30:23] == 8'd0) begin
         div_init.spec = 1'b1;
         div_init.spec_val = {div_init.sign, 31'd0};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div
         div_st_t st_d, st_q;
         if (gi == 0) begin : g_first
            always_comb st_d = div_step(div_init);
         end else begin : g_next
            always_comb st_d = div_step(div_q[gi-1]);
         end
         always_ff @(posedge clock or negedge rst) begin
            if (!rst) st_q <= '0;
            else      st_q <= st_d;
         end
         assign div_q[gi] = st_q;
      end
   endgenerate

   // Quotient lies in (0.5, 2): normalise by at most one bit, then round to nearest even.
   always_comb begin
      logic [27:0]       quo;
      logic signed [9:0] ex;
      logic [24:0]       m25;
      quo = div_q[3].quo;
      ex = div_q[3].ex;
      m25 = '0;
      div_res_d = 32'd0;
      dbz_d = 1'b0;
      if (div_q[3].spec) begin
         div_res_d = div_q[3].spec_val;
         dbz_d = div_q[3].dbz;
      end else begin
         if (!quo[27]) begin
            quo = {quo[26:0], 1'b0};
            ex = ex - 10'sd1;
         end
         m25 = {1'b0, quo[27:4]} + 25'(quo[3] & ((|quo[2:0]) | (|div_q[3].rem) | quo[4]));
         if (m25[24]) ex = ex + 10'sd1;
         if (ex >= 10'sd255)     div_res_d = {div_q[3].sign, 8'hFF, 23'd0};
         else if (ex <= 10'sd0)  div_res_d = {div_q[3].sign, 31'd0};
         else                    div_res_d = {div_q[3].sign, ex[7:0], m25[22:0]};
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
         add_sub_q <= 1'b0;
         for (int i = 0; i < 6; i++) add_pipe_q[i] <= '0;
         for (int i = 0; i < 5; i++) ftoi_pipe_q[i] <= '0;
         div_res_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         add_sub_q <= add_sub_d;
         for (int i = 0; i < 6; i++) add_pipe_q[i] <= add_pipe_d[i];
         for (int i = 0; i < 5; i++) ftoi_pipe_q[i] <= ftoi_pipe_d[i];
         div_res_q <= div_res_d;
         dbz_q <= dbz_d;
      end
   end

   assign addsub_result = add_pipe_q[5];
   assign ftoi_result = ftoi_pipe_q[4];
   assign div_result = div_res_q;
   assign division_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_exec_arith.sv
// Directed bench for fp_exec_arith: exact-latency checks of each unit, streaming and async reset.
module tb_fp_exec_arith;
   logic        clock = 1'b0;
   logic        rst;
   logic        add_sub;
   logic [31:0] dataa, datab;
   logic [31:0] addsub_result, div_result, ftoi_result;
   logic        division_by_zero;
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] FILL = 32'h40E00000;
   localparam logic [31:0] ONE  = 32'h3F800000;

   logic [31:0] stream_in [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                   32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
   logic [31:0] stream_exp [10] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
                                    32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};

   fp_exec_arith dut (
      .clock(clock), .rst(rst), .add_sub(add_sub), .dataa(dataa), .datab(datab),
      .addsub_result(addsub_result), .div_result(div_result),
      .division_by_zero(division_by_zero), .ftoi_result(ftoi_result)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   // Idle operands give results distinct from every vector so off-by-one latency shows up.
   task automatic idle();
      dataa = FILL;
      datab = FILL;
      add_sub = 1'b1;
   endtask

   task automatic add_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic [31:0] want);
      @(negedge clock);
      dataa = a; datab = b; add_sub = as;
      @(negedge clock);
      idle();
      repeat (6) @(posedge clock);
      #1 check_eq(tag, addsub_result, want);
   endtask

   task automatic div_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input logic want_dbz);
      @(negedge clock);
      dataa = a; datab = b; add_sub = 1'b1;
      @(negedge clock);
      idle();
      repeat (5) @(posedge clock);
      #1;
      check_eq({tag, "_q"}, div_result, want);
      check_eq({tag, "_dbz"}, {31'd0, division_by_zero}, {31'd0, want_dbz});
   endtask

   task automatic ftoi_vec(input string tag, input logic [31:0] a, input logic [31:0] want);
      @(negedge clock);
      dataa = a; datab = FILL; add_sub = 1'b1;
      @(negedge clock);
      idle();
      repeat (5) @(posedge clock);
      #1 check_eq(tag, ftoi_result, want);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      repeat (3) @(negedge clock);
      check_eq("rst_add", addsub_result, 32'd0);
      check_eq("rst_div", div_result, 32'd0);
      check_eq("rst_dbz", {31'd0, division_by_zero}, 32'd0);
      check_eq("rst_ftoi", ftoi_result, 32'd0);
      rst = 1'b1;

      add_vec("add_1p2", 32'h3F800000, 32'h40000000, 1'b1, 32'h40400000);
      add_vec("sub_1m2", 32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000);
      add_vec("sub_1m1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000);
      add_vec("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000);
      add_vec("max_p_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000);
      add_vec("denorm_p0", 32'h00000001, 32'h00000000, 1'b1, 32'h00000000);
      add_vec("nz_p_nz", 32'h80000000, 32'h80000000, 1'b1, 32'h80000000);
      add_vec("tie_even", ONE, 32'h33800000, 1'b1, 32'h3F800000);
      add_vec("above_tie", ONE, 32'h33800001, 1'b1, 32'h3F800001);

      div_vec("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      div_vec("div_1_0", ONE, 32'h00000000, 32'h7F800000, 1'b1);
      div_vec("div_m1_0", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
      div_vec("div_0_0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
      div_vec("div_1_3", ONE, 32'h40400000, 32'h3EAAAAAB, 1'b0);
      div_vec("div_1_inf", ONE, 32'h7F800000, 32'h00000000, 1'b0);
      div_vec("div_ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0);
      div_vec("div_unf", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);

      ftoi_vec("ftoi_2p5", 32'h40200000, 32'h00000002);
      ftoi_vec("ftoi_m3p5", 32'hC0600000, 32'hFFFFFFFC);
      ftoi_vec("ftoi_3e9", 32'h4F32D05E, 32'h7FFFFFFF);
      ftoi_vec("ftoi_m2p32", 32'hCF800000, 32'h80000000);
      ftoi_vec("ftoi_1p5", 32'h3FC00000, 32'h00000002);
      ftoi_vec("ftoi_0p5", 32'h3F000000, 32'h00000000);
      ftoi_vec("ftoi_100", 32'h42C80000, 32'h00000064);
      ftoi_vec("ftoi_nan", 32'h7FC00000, 32'h7FFFFFFF);
      ftoi_vec("ftoi_minf", 32'hFF800000, 32'h80000000);

      // Input c is sampled at the edge after negedge c; its sum is visible at negedge c+7.
      for (int c = 0; c < 18; c++) begin
         @(negedge clock);
         if (c >= 7 && c < 17) check_eq($sformatf("stream%0d", c - 7), addsub_result, stream_exp[c - 7]);
         if (c < 10) begin
            dataa = stream_in[c]; datab = ONE; add_sub = 1'b1;
         end else begin
            idle();
         end
      end

      @(negedge clock);
      dataa = ONE; datab = 32'h40000000; add_sub = 1'b1;
      @(negedge clock);
      idle();
      repeat (3) @(posedge clock);
      #2 rst = 1'b0;
      #1;
      check_eq("rstmid_add", addsub_result, 32'd0);
      check_eq("rstmid_div", div_result, 32'd0);
      check_eq("rstmid_dbz", {31'd0, division_by_zero}, 32'd0);
      check_eq("rstmid_ftoi", ftoi_result, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_eq($sformatf("rsthold%0d_add", i), addsub_result, 32'd0);
         check_eq($sformatf("rsthold%0d_ftoi", i), ftoi_result, 32'd0);
      end
      @(negedge clock);
      rst = 1'b1;
      add_vec("post_rst_2p2", 32'h40000000, 32'h40000000, 1'b1, 32'h40800000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
